// File: rtl/mrv1_opc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mrv1_opc_sequencer_if
// Bundles every non-clock/reset signal of the operand-fetch sequencer.
// Signal suffixes are from the sequencer's point of view (_i = into it).
//   Issue side    : req_valid_i, req_ready_o, req_rs0_en_i, req_rs1_en_i,
//                   req_rs0_addr_i, req_rs1_addr_i (thread t at [t*RA +: RA])
//   Register file : rf_rd_en_o, rf_rd_tid_o, rf_rd_addr_o, rf_rd_data_i
//   Execute side  : exe_valid_o, exe_ready_i, exe_tid_o, rs0_data_o, rs1_data_o
//   Status        : busy_o
// slave  = sequencer side, master = environment (issue/RF/execute) side.
// ---------------------------------------------------------------------------
interface mrv1_opc_sequencer_if #(
  parameter int NUM_THREADS_P    = 4,
  parameter int TID_WIDTH_P      = 2,
  parameter int DATA_WIDTH_P     = 32,
  parameter int REG_ADDR_WIDTH_P = 5
);
  logic [NUM_THREADS_P-1:0]                  req_valid_i;
  logic [NUM_THREADS_P-1:0]                  req_ready_o;
  logic [NUM_THREADS_P-1:0]                  req_rs0_en_i;
  logic [NUM_THREADS_P-1:0]                  req_rs1_en_i;
  logic [NUM_THREADS_P*REG_ADDR_WIDTH_P-1:0] req_rs0_addr_i;
  logic [NUM_THREADS_P*REG_ADDR_WIDTH_P-1:0] req_rs1_addr_i;

  logic                        rf_rd_en_o;
  logic [TID_WIDTH_P-1:0]      rf_rd_tid_o;
  logic [REG_ADDR_WIDTH_P-1:0] rf_rd_addr_o;
  logic [DATA_WIDTH_P-1:0]     rf_rd_data_i;

  logic                    exe_valid_o;
  logic                    exe_ready_i;
  logic [TID_WIDTH_P-1:0]  exe_tid_o;
  logic [DATA_WIDTH_P-1:0] rs0_data_o;
  logic [DATA_WIDTH_P-1:0] rs1_data_o;
  logic                    busy_o;

  modport slave (
    input  req_valid_i, req_rs0_en_i, req_rs1_en_i, req_rs0_addr_i, req_rs1_addr_i,
    output req_ready_o,
    output rf_rd_en_o, rf_rd_tid_o, rf_rd_addr_o,
    input  rf_rd_data_i,
    output exe_valid_o, exe_tid_o, rs0_data_o, rs1_data_o,
    input  exe_ready_i,
    output busy_o
  );

  modport master (
    output req_valid_i, req_rs0_en_i, req_rs1_en_i, req_rs0_addr_i, req_rs1_addr_i,
    input  req_ready_o,
    input  rf_rd_en_o, rf_rd_tid_o, rf_rd_addr_o,
    output rf_rd_data_i,
    input  exe_valid_o, exe_tid_o, rs0_data_o, rs1_data_o,
    output exe_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/mrv1_opc_sequencer.sv
// ---------------------------------------------------------------------------
// mrv1_opc_sequencer
// Operand-fetch sequencer in front of the execute source mux. Round-robin
// arbitrates per-thread issue requests, reads rs0 then rs1 through the single
// shared RF read port, captures the returned data and presents both operands
// with the owning thread ID to execute over a valid/ready handshake.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   bus     - mrv1_opc_sequencer_if.slave (issue, RF read port, execute, busy)
// ---------------------------------------------------------------------------
module mrv1_opc_sequencer #(
  parameter int NUM_THREADS_P    = 4,
  parameter int TID_WIDTH_P      = 2,
  parameter int DATA_WIDTH_P     = 32,
  parameter int REG_ADDR_WIDTH_P = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  mrv1_opc_sequencer_if.slave        bus
);

  localparam int NT = NUM_THREADS_P;
  localparam int TW = TID_WIDTH_P;
  localparam int DW = DATA_WIDTH_P;
  localparam int RA = REG_ADDR_WIDTH_P;

  typedef enum logic [2:0] {IDLE, RD0, RD1, DRAIN, OUT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_last;
  logic [TW-1:0] r_tid;
  logic          r_rs1_en;
  logic [RA-1:0] r_rs1_addr;
  logic          r_rd_en;
  logic [TW-1:0] r_rd_tid;
  logic [RA-1:0] r_rd_addr;
  logic          r_pend;
  logic          r_dst;
  logic [DW-1:0] r_rs0_data;
  logic [DW-1:0] r_rs1_data;
  logic          r_exe_valid;
  logic          r_busy;

  logic          w_found;
  logic [TW-1:0] w_winner;
  logic          w_grant;
  logic [NT-1:0] w_ready;
  logic [RA-1:0] w_rs0_addr;
  logic [RA-1:0] w_rs1_addr;

  // Round-robin scan starting just after the last winner, wrapping modulo NT.
  always_comb begin : p_arb
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NT; i++) begin
      if (!w_found && bus.req_valid_i[TW'((int'(r_last) + i) % NT)]) begin
        w_found  = 1'b1;
        w_winner = TW'((int'(r_last) + i) % NT);
      end
    end
  end

  // Grant only in IDLE; gated by reset so every output reads 0 while held.
  assign w_grant    = (r_state == IDLE) && w_found && rst_ni;
  assign w_ready    = w_grant ? (NT'(1) << w_winner) : '0;
  assign w_rs0_addr = bus.req_rs0_addr_i[w_winner*RA +: RA];
  assign w_rs1_addr = bus.req_rs1_addr_i[w_winner*RA +: RA];

  assign bus.req_ready_o  = w_ready;
  assign bus.rf_rd_en_o   = r_rd_en;
  assign bus.rf_rd_tid_o  = r_rd_tid;
  assign bus.rf_rd_addr_o = r_rd_addr;
  assign bus.exe_valid_o  = r_exe_valid;
  assign bus.exe_tid_o    = r_tid;
  assign bus.rs0_data_o   = r_rs0_data;
  assign bus.rs1_data_o   = r_rs1_data;
  assign bus.busy_o       = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_last      <= TW'(NT - 1);
      r_tid       <= '0;
      r_rs1_en    <= 1'b0;
      r_rs1_addr  <= '0;
      r_rd_en     <= 1'b0;
      r_rd_tid    <= '0;
      r_rd_addr   <= '0;
      r_pend      <= 1'b0;
      r_dst       <= 1'b0;
      r_rs0_data  <= '0;
      r_rs1_data  <= '0;
      r_exe_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // RF data lags the strobe by one cycle: remember that a read was issued
      // and which operand it was for, then capture on the following cycle.
      r_pend <= r_rd_en;
      r_dst  <= (r_state == RD1);
      if (r_pend) begin
        if (r_dst) r_rs1_data <= bus.rf_rd_data_i;
        else       r_rs0_data <= bus.rf_rd_data_i;
      end

      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_tid      <= w_winner;
            r_last     <= w_winner;
            r_rs1_en   <= bus.req_rs1_en_i[w_winner];
            r_rs1_addr <= w_rs1_addr;
            r_rs0_data <= '0;
            r_rs1_data <= '0;
            r_busy     <= 1'b1;
            if (bus.req_rs0_en_i[w_winner]) begin
              r_state   <= RD0;
              r_rd_en   <= 1'b1;
              r_rd_tid  <= w_winner;
              r_rd_addr <= w_rs0_addr;
            end else if (bus.req_rs1_en_i[w_winner]) begin
              r_state   <= RD1;
              r_rd_en   <= 1'b1;
              r_rd_tid  <= w_winner;
              r_rd_addr <= w_rs1_addr;
            end else begin
              r_state     <= OUT;
              r_exe_valid <= 1'b1;
            end
          end
        end
        RD0: begin
          if (r_rs1_en) begin
            r_state   <= RD1;
            r_rd_addr <= r_rs1_addr;
          end else begin
            r_state   <= DRAIN;
            r_rd_en   <= 1'b0;
            r_rd_tid  <= '0;
            r_rd_addr <= '0;
          end
        end
        RD1: begin
          r_state   <= DRAIN;
          r_rd_en   <= 1'b0;
          r_rd_tid  <= '0;
          r_rd_addr <= '0;
        end
        DRAIN: begin
          r_state     <= OUT;
          r_exe_valid <= 1'b1;
        end
        OUT: begin
          if (bus.exe_ready_i) begin
            r_state     <= IDLE;
            r_exe_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrv1_opc_sequencer.sv
module tb_mrv1_opc_sequencer;
  localparam int NT = 4;
  localparam int TW = 2;
  localparam int DW = 32;
  localparam int RA = 5;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  always #5 clk_i = ~clk_i;

  mrv1_opc_sequencer_if #(.NUM_THREADS_P(NT), .TID_WIDTH_P(TW),
                          .DATA_WIDTH_P(DW), .REG_ADDR_WIDTH_P(RA)) bus();

  mrv1_opc_sequencer #(.NUM_THREADS_P(NT), .TID_WIDTH_P(TW),
                       .DATA_WIDTH_P(DW), .REG_ADDR_WIDTH_P(RA)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // RF model: data = {tid, addr} as hex nibbles, one cycle after the strobe;
  // a junk pattern otherwise so a stray capture shows up.
  always @(posedge clk_i)
    bus.rf_rd_data_i <= bus.rf_rd_en_o ?
      ((DW'(bus.rf_rd_tid_o) << 4) | DW'(bus.rf_rd_addr_o)) : 32'hDEAD_BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_req;
    bus.req_valid_i    = '0;
    bus.req_rs0_en_i   = '0;
    bus.req_rs1_en_i   = '0;
    bus.req_rs0_addr_i = '0;
    bus.req_rs1_addr_i = '0;
  endtask

  task automatic set_thread(input int t, input logic e0, input logic e1,
                            input logic [RA-1:0] a0, input logic [RA-1:0] a1);
    bus.req_rs0_en_i[t]            = e0;
    bus.req_rs1_en_i[t]            = e1;
    bus.req_rs0_addr_i[t*RA +: RA] = a0;
    bus.req_rs1_addr_i[t*RA +: RA] = a1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    clear_req();
    bus.exe_ready_i = 1'b0;
    do_reset();
    tests++;
    if ({bus.req_ready_o, bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o} !== '0) begin
      fails++;
      $display("FAIL reset_rf: got ready=%b en=%b tid=%0d addr=%0d want all 0",
               bus.req_ready_o, bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o);
    end
    tests++;
    if ({bus.exe_valid_o, bus.exe_tid_o, bus.busy_o} !== '0) begin
      fails++;
      $display("FAIL reset_exe: got valid=%b tid=%0d busy=%b want 0",
               bus.exe_valid_o, bus.exe_tid_o, bus.busy_o);
    end
    tests++;
    if ({bus.rs0_data_o, bus.rs1_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_data: got rs0=%h rs1=%h want 0", bus.rs0_data_o, bus.rs1_data_o);
    end
  endtask

  task automatic test_round_robin;
    int got [6];
    int exp_o [6] = '{0, 1, 2, 3, 0, 1};
    int n = 0;
    clear_req();
    do_reset();
    bus.exe_ready_i = 1'b1;
    bus.req_valid_i = 4'b1111;
    #1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (bus.req_ready_o != '0) begin
        tests++;
        if (bus.busy_o !== 1'b0 || !$onehot(bus.req_ready_o)) begin
          fails++;
          $display("FAIL rr_single_grant: got busy=%b ready=%b want busy=0 one-hot",
                   bus.busy_o, bus.req_ready_o);
        end
        for (int b = 0; b < NT; b++) if (bus.req_ready_o[b]) got[n] = b;
        n++;
      end
      tick();
    end
    bus.req_valid_i = '0;
    for (int c = 0; c < 10 && bus.busy_o !== 1'b0; c++) tick();
    bus.exe_ready_i = 1'b0;
    tests++;
    if (n != 6 || bus.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rr_count: got %0d grants busy=%b want 6 grants busy=0", n, bus.busy_o);
    end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got[i] != exp_o[i]) begin
        fails++;
        $display("FAIL rr_order[%0d]: got thread %0d want %0d", i, got[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_two_ops;
    clear_req();
    set_thread(2, 1'b1, 1'b1, 5'd5, 5'd7);
    bus.req_valid_i = 4'b0100;
    #1;
    tests++;
    if (bus.req_ready_o !== 4'b0100) begin
      fails++; $display("FAIL two_grant: got %b want 0100", bus.req_ready_o);
    end
    tick(); bus.req_valid_i = '0;
    tests++;
    if ({bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o, bus.exe_valid_o, bus.busy_o}
        !== {1'b1, 2'd2, 5'd5, 1'b0, 1'b1}) begin
      fails++; $display("FAIL two_rd0: got en=%b tid=%0d addr=%0d valid=%b busy=%b want 1,2,5,0,1",
                        bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o, bus.exe_valid_o, bus.busy_o);
    end
    tick();
    tests++;
    if ({bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o} !== {1'b1, 2'd2, 5'd7}) begin
      fails++; $display("FAIL two_rd1: got en=%b tid=%0d addr=%0d want 1,2,7",
                        bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o);
    end
    tick();
    tests++;
    if ({bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o, bus.exe_valid_o} !== '0) begin
      fails++; $display("FAIL two_drain: got en=%b tid=%0d addr=%0d valid=%b want all 0",
                        bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o, bus.exe_valid_o);
    end
    tick();
    tests++;
    if ({bus.exe_valid_o, bus.exe_tid_o, bus.rs0_data_o, bus.rs1_data_o}
        !== {1'b1, 2'd2, 32'h25, 32'h27}) begin
      fails++; $display("FAIL two_out: got valid=%b tid=%0d rs0=%h rs1=%h want 1,2,25,27",
                        bus.exe_valid_o, bus.exe_tid_o, bus.rs0_data_o, bus.rs1_data_o);
    end
    bus.exe_ready_i = 1'b1;
    tick();
    bus.exe_ready_i = 1'b0;
    tests++;
    if ({bus.exe_valid_o, bus.busy_o} !== 2'b00) begin
      fails++; $display("FAIL two_done: got valid=%b busy=%b want 0,0", bus.exe_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_rs1_only;
    clear_req();
    set_thread(1, 1'b0, 1'b1, 5'd9, 5'd3);
    bus.exe_ready_i = 1'b1;
    bus.req_valid_i = 4'b0010;
    #1;
    tests++;
    if (bus.req_ready_o !== 4'b0010) begin
      fails++; $display("FAIL rs1_grant: got %b want 0010", bus.req_ready_o);
    end
    tick(); bus.req_valid_i = '0;
    tests++;
    if ({bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o} !== {1'b1, 2'd1, 5'd3}) begin
      fails++; $display("FAIL rs1_rd: got en=%b tid=%0d addr=%0d want 1,1,3",
                        bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o);
    end
    tick();
    tests++;
    if ({bus.rf_rd_en_o, bus.exe_valid_o, bus.busy_o} !== 3'b001) begin
      fails++; $display("FAIL rs1_drain: got en=%b valid=%b busy=%b want 0,0,1",
                        bus.rf_rd_en_o, bus.exe_valid_o, bus.busy_o);
    end
    tick();
    tests++;
    if ({bus.exe_valid_o, bus.exe_tid_o, bus.rs0_data_o, bus.rs1_data_o}
        !== {1'b1, 2'd1, 32'h0, 32'h13}) begin
      fails++; $display("FAIL rs1_out: got valid=%b tid=%0d rs0=%h rs1=%h want 1,1,0,13",
                        bus.exe_valid_o, bus.exe_tid_o, bus.rs0_data_o, bus.rs1_data_o);
    end
    tick();
    bus.exe_ready_i = 1'b0;
    tests++;
    if ({bus.exe_valid_o, bus.busy_o} !== 2'b00) begin
      fails++; $display("FAIL rs1_done: got valid=%b busy=%b want 0,0", bus.exe_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_no_ops;
    clear_req();
    set_thread(3, 1'b0, 1'b0, 5'd1, 5'd2);
    bus.req_valid_i = 4'b1000;
    #1;
    tests++;
    if (bus.req_ready_o !== 4'b1000) begin
      fails++; $display("FAIL none_grant: got %b want 1000", bus.req_ready_o);
    end
    tick(); bus.req_valid_i = '0;
    tests++;
    if ({bus.exe_valid_o, bus.exe_tid_o, bus.rf_rd_en_o, bus.rs0_data_o, bus.rs1_data_o}
        !== {1'b1, 2'd3, 1'b0, 32'h0, 32'h0}) begin
      fails++; $display("FAIL none_out: got valid=%b tid=%0d en=%b rs0=%h rs1=%h want 1,3,0,0,0",
                        bus.exe_valid_o, bus.exe_tid_o, bus.rf_rd_en_o, bus.rs0_data_o, bus.rs1_data_o);
    end
    bus.exe_ready_i = 1'b1;
    tick();
    bus.exe_ready_i = 1'b0;
    tests++;
    if (bus.busy_o !== 1'b0) begin
      fails++; $display("FAIL none_done: got busy=%b want 0", bus.busy_o);
    end
  endtask

  task automatic test_backpressure;
    clear_req();
    set_thread(0, 1'b1, 1'b0, 5'd2, 5'd4);
    bus.req_valid_i = 4'b0111;
    #1;
    tests++;
    if (bus.req_ready_o !== 4'b0001) begin
      fails++; $display("FAIL bp_grant: got %b want 0001", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 4'b0110;
    set_thread(0, 1'b1, 1'b1, 5'd9, 5'd9);
    #1;
    tests++;
    if ({bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o, bus.req_ready_o}
        !== {1'b1, 2'd0, 5'd2, 4'b0000}) begin
      fails++; $display("FAIL bp_rd0: got en=%b tid=%0d addr=%0d ready=%b want 1,0,2,0000",
                        bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o, bus.req_ready_o);
    end
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if ({bus.exe_valid_o, bus.exe_tid_o, bus.rs0_data_o, bus.rs1_data_o, bus.req_ready_o}
          !== {1'b1, 2'd0, 32'h02, 32'h0, 4'b0000}) begin
        fails++; $display("FAIL bp_hold[%0d]: got valid=%b tid=%0d rs0=%h rs1=%h ready=%b want 1,0,02,0,0000",
                          k, bus.exe_valid_o, bus.exe_tid_o, bus.rs0_data_o, bus.rs1_data_o, bus.req_ready_o);
      end
      tick();
    end
    bus.exe_ready_i = 1'b1;
    tick();
    bus.exe_ready_i = 1'b0;
    tests++;
    if ({bus.exe_valid_o, bus.busy_o, bus.req_ready_o} !== {1'b0, 1'b0, 4'b0010}) begin
      fails++; $display("FAIL bp_next: got valid=%b busy=%b ready=%b want 0,0,0010",
                        bus.exe_valid_o, bus.busy_o, bus.req_ready_o);
    end
    bus.req_valid_i = '0;
    tick();
  endtask

  task automatic test_async_reset;
    clear_req();
    set_thread(2, 1'b1, 1'b1, 5'd4, 5'd6);
    bus.req_valid_i = 4'b0100;
    #1;
    tests++;
    if (bus.req_ready_o !== 4'b0100) begin
      fails++; $display("FAIL ar_grant: got %b want 0100", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 4'b0101;
    tick();
    tests++;
    if ({bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o} !== {1'b1, 2'd2, 5'd6}) begin
      fails++; $display("FAIL ar_rd1: got en=%b tid=%0d addr=%0d want 1,2,6",
                        bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    tests++;
    if ({bus.req_ready_o, bus.rf_rd_en_o, bus.rf_rd_tid_o, bus.rf_rd_addr_o,
         bus.exe_valid_o, bus.exe_tid_o, bus.busy_o, bus.rs0_data_o, bus.rs1_data_o} !== '0) begin
      fails++; $display("FAIL ar_in_reset: got ready=%b en=%b valid=%b busy=%b rs0=%h rs1=%h want all 0",
                        bus.req_ready_o, bus.rf_rd_en_o, bus.exe_valid_o, bus.busy_o,
                        bus.rs0_data_o, bus.rs1_data_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    tests++;
    if (bus.req_ready_o !== 4'b0001) begin
      fails++; $display("FAIL ar_first_grant: got %b want 0001", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = '0;
    tests++;
    if ({bus.exe_valid_o, bus.exe_tid_o, bus.rf_rd_en_o, bus.rs0_data_o, bus.rs1_data_o}
        !== {1'b1, 2'd0, 1'b0, 32'h0, 32'h0}) begin
      fails++; $display("FAIL ar_out: got valid=%b tid=%0d en=%b rs0=%h rs1=%h want 1,0,0,0,0",
                        bus.exe_valid_o, bus.exe_tid_o, bus.rf_rd_en_o, bus.rs0_data_o, bus.rs1_data_o);
    end
    bus.exe_ready_i = 1'b1;
    tick();
    bus.exe_ready_i = 1'b0;
    tests++;
    if (bus.busy_o !== 1'b0) begin
      fails++; $display("FAIL ar_done: got busy=%b want 0", bus.busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_two_ops();
    test_rs1_only();
    test_no_ops();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
